// File: rtl/jedro_1_defines.sv
// jedro_1 shared decode constants:
// opcodes, ALU op encodings, width defaults.
package jedro_1_defines;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int ADDR_WIDTH_DEF   = 5;
  localparam int ALU_OP_WIDTH_DEF = 4;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/jedro_1_imm_gen.sv
// jedro_1 immediate generator: extracts the
// immediate for a format, sign-extended from bit 31.
module jedro_1_imm_gen
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
  input  logic [31:0]           instr,
  input  imm_fmt_e              format,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] raw;
  logic        unused_opc;

  assign unused_opc = ^instr[6:0];

  always_comb begin
    raw = '0;
    unique case (format)
      IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S: raw = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      IMM_B: raw = {{19{instr[31]}}, instr[31],
                    instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: raw = {instr[31:12], 12'b0};
      IMM_J: raw = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(raw));

endmodule

// File: rtl/jedro_1_idu.sv
// jedro_1 instruction decode unit: one-deep
// registered decode stage with valid/ready handshake.
module jedro_1_idu
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int ALU_OP_WIDTH = ALU_OP_WIDTH_DEF,
  parameter bit RVE          = 1'b0
)(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             instr_rdata_i,
  input  logic [DATA_WIDTH-1:0]   pc_i,
  input  logic                    flush_i,
  output logic [ADDR_WIDTH-1:0]   reg_a_addr_o,
  input  logic [DATA_WIDTH-1:0]   reg_a_data_i,
  output logic [ADDR_WIDTH-1:0]   reg_b_addr_o,
  input  logic [DATA_WIDTH-1:0]   reg_b_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ALU_OP_WIDTH-1:0] alu_op_sel_o,
  output logic [DATA_WIDTH-1:0]   alu_op_a_o,
  output logic [DATA_WIDTH-1:0]   alu_op_b_o,
  output logic [ADDR_WIDTH-1:0]   rd_addr_o,
  output logic                    rd_we_o,
  output logic                    illegal_instr_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = instr_rdata_i[6:0];
  assign rd     = instr_rdata_i[11:7];
  assign funct3 = instr_rdata_i[14:12];
  assign rs1    = instr_rdata_i[19:15];
  assign rs2    = instr_rdata_i[24:20];
  assign funct7 = instr_rdata_i[31:25];

  assign reg_a_addr_o = ADDR_WIDTH'(rs1);
  assign reg_b_addr_o = ADDR_WIDTH'(rs2);

  logic is_op, is_op_imm, is_lui, is_auipc;
  logic is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_fence, is_system;

  assign is_op     = opcode == OPC_OP;
  assign is_op_imm = opcode == OPC_OP_IMM;
  assign is_lui    = opcode == OPC_LUI;
  assign is_auipc  = opcode == OPC_AUIPC;
  assign is_load   = opcode == OPC_LOAD;
  assign is_store  = opcode == OPC_STORE;
  assign is_branch = opcode == OPC_BRANCH;
  assign is_jal    = opcode == OPC_JAL;
  assign is_jalr   = opcode == OPC_JALR;
  assign is_fence  = opcode == OPC_MISC_MEM;
  assign is_system = opcode == OPC_SYSTEM;

  imm_fmt_e              fmt;
  logic [DATA_WIDTH-1:0] imm;

  assign fmt = (is_lui || is_auipc) ? IMM_U :
               is_store             ? IMM_S :
               is_branch            ? IMM_B :
               is_jal               ? IMM_J :
                                      IMM_I;

  jedro_1_imm_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_imm_gen (
    .instr  (instr_rdata_i),
    .format (fmt),
    .imm    (imm)
  );

  logic                  ill;
  logic                  we;
  logic [3:0]            sel;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  use_rd;
  logic                  use_rs1;
  logic                  use_rs2;

  always_comb begin
    ill     = 1'b0;
    we      = 1'b0;
    sel     = ALU_ADD;
    op_a    = '0;
    op_b    = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (1'b1)
      is_op: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        we      = 1'b1;
        op_a    = reg_a_data_i;
        op_b    = reg_b_data_i;
        sel     = {instr_rdata_i[30], funct3};
        if (funct7 == F7_ALT)
          ill = !(funct3 == 3'b000 ||
                  funct3 == 3'b101);
        else if (funct7 != F7_BASE)
          ill = 1'b1;
      end
      is_op_imm: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        we      = 1'b1;
        op_a    = reg_a_data_i;
        op_b    = imm;
        // only shifts carry a funct7 qualifier
        if (funct3 == 3'b101) begin
          sel = {instr_rdata_i[30], funct3};
          ill = !(funct7 == F7_BASE ||
                  funct7 == F7_ALT);
        end else begin
          sel = {1'b0, funct3};
          if (funct3 == 3'b001)
            ill = funct7 != F7_BASE;
        end
      end
      is_lui: begin
        use_rd = 1'b1;
        we     = 1'b1;
        op_b   = imm;
      end
      is_auipc: begin
        use_rd = 1'b1;
        we     = 1'b1;
        op_a   = pc_i;
        op_b   = imm;
      end
      is_load, is_jalr: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_store, is_branch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      is_jal:              use_rd = 1'b1;
      is_fence, is_system: ill = 1'b0;
      default:             ill = 1'b1;
    endcase
    if (instr_rdata_i[1:0] != 2'b11)
      ill = 1'b1;
    if (RVE && ((use_rd  && rd[4])  ||
                (use_rs1 && rs1[4]) ||
                (use_rs2 && rs2[4])))
      ill = 1'b1;
    if (rd == 5'd0)
      we = 1'b0;
    if (ill) begin
      we   = 1'b0;
      sel  = '0;
      op_a = '0;
      op_b = '0;
    end
  end

  logic accept;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o     <= 1'b0;
      alu_op_sel_o    <= '0;
      alu_op_a_o      <= '0;
      alu_op_b_o      <= '0;
      rd_addr_o       <= '0;
      rd_we_o         <= 1'b0;
      illegal_instr_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o     <= 1'b1;
      alu_op_sel_o    <= ALU_OP_WIDTH'(sel);
      alu_op_a_o      <= op_a;
      alu_op_b_o      <= op_b;
      rd_addr_o       <= ADDR_WIDTH'(rd);
      rd_we_o         <= we;
      illegal_instr_o <= ill;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jedro_1_idu.sv
// Scoreboard bench for jedro_1_idu: random and
// directed instructions against a behavioural decode model.
module tb_jedro_1_idu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic [4:0]  ra_addr, rb_addr;
  logic [31:0] ra_data, rb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        ill;

  logic        r_in_ready;
  logic [4:0]  r_ra_addr, r_rb_addr;
  logic [31:0] r_ra_data, r_rb_data;
  logic        r_out_valid;
  logic [3:0]  r_sel;
  logic [31:0] r_a, r_b;
  logic [4:0]  r_rd;
  logic        r_we;
  logic        r_ill;

  logic [31:0] rf [32];

  assign ra_data   = rf[ra_addr];
  assign rb_data   = rf[rb_addr];
  assign r_ra_data = rf[r_ra_addr];
  assign r_rb_data = rf[r_rb_addr];

  always #5 clk = ~clk;

  jedro_1_idu u_dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .instr_rdata_i   (instr),
    .pc_i            (pc_in),
    .flush_i         (flush),
    .reg_a_addr_o    (ra_addr),
    .reg_a_data_i    (ra_data),
    .reg_b_addr_o    (rb_addr),
    .reg_b_data_i    (rb_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .alu_op_sel_o    (alu_sel),
    .alu_op_a_o      (alu_a),
    .alu_op_b_o      (alu_b),
    .rd_addr_o       (rd_addr),
    .rd_we_o         (rd_we),
    .illegal_instr_o (ill)
  );

  jedro_1_idu #(.RVE(1)) u_rve (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .in_valid_i      (in_valid),
    .in_ready_o      (r_in_ready),
    .instr_rdata_i   (instr),
    .pc_i            (pc_in),
    .flush_i         (flush),
    .reg_a_addr_o    (r_ra_addr),
    .reg_a_data_i    (r_ra_data),
    .reg_b_addr_o    (r_rb_addr),
    .reg_b_data_i    (r_rb_data),
    .out_valid_o     (r_out_valid),
    .out_ready_i     (out_ready),
    .alu_op_sel_o    (r_sel),
    .alu_op_a_o      (r_a),
    .alu_op_b_o      (r_b),
    .rd_addr_o       (r_rd),
    .rd_we_o         (r_we),
    .illegal_instr_o (r_ill)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic        we_e;
    logic        ill_e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic mvalid = 1'b0;
  logic exp_vnow = 1'b0;
  logic mon_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected decode from the ISA rules; ill_e/we_e
  // are the RV32E variant of the same instruction.
  function automatic exp_t model(logic [31:0] ins,
                                 logic [31:0] pc);
    exp_t       e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] d, s1, s2;
    bit         ok, big, urd, us1, us2;
    e   = '0;
    f7  = ins[31:25];
    f3  = ins[14:12];
    d   = ins[11:7];
    s1  = ins[19:15];
    s2  = ins[24:20];
    ok  = 1;
    urd = 0;
    us1 = 0;
    us2 = 0;
    e.rd = d;
    case (ins[6:0])
      7'h33: begin
        urd = 1; us1 = 1; us2 = 1;
        ok = (f7 == 0) ||
             (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.sel = {ins[30], f3};
        e.a = rf[s1];
        e.b = rf[s2];
        e.we = 1;
      end
      7'h13: begin
        urd = 1; us1 = 1;
        e.a = rf[s1];
        e.b = 32'($signed(ins[31:20]));
        e.we = 1;
        e.sel = (f3 == 5) ? {ins[30], f3} : {1'b0, f3};
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
      end
      7'h37: begin
        urd = 1;
        e.b = {ins[31:12], 12'h000};
        e.we = 1;
      end
      7'h17: begin
        urd = 1;
        e.a = pc;
        e.b = {ins[31:12], 12'h000};
        e.we = 1;
      end
      7'h03, 7'h67: begin urd = 1; us1 = 1; end
      7'h23, 7'h63: begin us1 = 1; us2 = 1; end
      7'h6f: urd = 1;
      7'h0f, 7'h73: ok = 1;
      default: ok = 0;
    endcase
    if (ins[1:0] != 2'b11) ok = 0;
    if (d == 0) e.we = 0;
    big = (urd && d >= 16) || (us1 && s1 >= 16) ||
          (us2 && s2 >= 16);
    e.ill   = !ok;
    e.ill_e = !ok || big;
    e.we_e  = e.we && ok && !big;
    if (!ok) begin
      e.we  = 0;
      e.sel = 0;
      e.a   = 0;
      e.b   = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: begin
        r[6:0] = 7'h33;
        if ($urandom_range(0, 3) != 0)
          r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      3, 4: begin
        r[6:0] = 7'h13;
        if ($urandom_range(0, 2) != 0)
          r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      5: r[6:0] = 7'h37;
      6: r[6:0] = 7'h17;
      7: begin
        case ($urandom_range(0, 6))
          0: r[6:0] = 7'h03;
          1: r[6:0] = 7'h23;
          2: r[6:0] = 7'h63;
          3: r[6:0] = 7'h6f;
          4: r[6:0] = 7'h67;
          5: r[6:0] = 7'h0f;
          default: r[6:0] = 7'h73;
        endcase
      end
      default: ;
    endcase
    if ($urandom_range(0, 1) != 0) begin
      r[24] = 0;
      r[19] = 0;
      r[11] = 0;
    end
    return r;
  endfunction

  task automatic drive(bit v, logic [31:0] ins,
                       logic [31:0] pc, bit rdy,
                       bit fl, bit mut);
    bit acc;
    @(negedge clk);
    if (mut) rf[$urandom_range(1, 31)] = $urandom;
    in_valid  = v;
    instr     = ins;
    pc_in     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_vnow = mvalid;
    chk("in_ready", 32'(in_ready), 32'(!mvalid || rdy));
    chk("rve_in_ready", 32'(r_in_ready),
        32'(!mvalid || rdy));
    chk("rs1_addr", 32'(ra_addr), 32'(ins[19:15]));
    chk("rs2_addr", 32'(rb_addr), 32'(ins[24:20]));
    acc = v && (!mvalid || rdy);
    if (fl) begin
      mvalid = 0;
    end else if (acc) begin
      q.push_back(model(ins, pc));
      mvalid = 1;
    end else if (rdy) begin
      mvalid = 0;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("out_valid", 32'(out_valid), 32'(exp_vnow));
        chk("rve_out_valid", 32'(r_out_valid),
            32'(exp_vnow));
        if (exp_vnow) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: result, queue empty");
          end else begin
            e = q[0];
            chk("alu_sel", 32'(alu_sel), 32'(e.sel));
            chk("op_a", alu_a, e.a);
            chk("op_b", alu_b, e.b);
            chk("rd_addr", 32'(rd_addr), 32'(e.rd));
            chk("rd_we", 32'(rd_we), 32'(e.we));
            chk("illegal", 32'(ill), 32'(e.ill));
            chk("rve_illegal", 32'(r_ill), 32'(e.ill_e));
            chk("rve_rd_we", 32'(r_we), 32'(e.we_e));
            chk("rve_sel", 32'(r_sel),
                e.ill_e ? 32'd0 : 32'(e.sel));
            chk("rve_a", r_a, e.ill_e ? 32'd0 : e.a);
            chk("rve_b", r_b, e.ill_e ? 32'd0 : e.b);
            chk("rve_rd", 32'(r_rd), 32'(e.rd));
            if (out_ready || flush)
              void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rstn      = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    pc_in     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rf[0]     = '0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    #1 rstn = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(alu_sel), 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_we", 32'(rd_we), 0);
    chk("rst_ill", 32'(ill), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;

    rf[1] = 32'd5;
    rf[2] = 32'd7;
    drive(1, 32'h002081B3, 0, 1, 0, 0);
    drive(1, 32'h402081B3, 0, 1, 0, 0);
    drive(1, 32'hFFF00093, 0, 1, 0, 0);
    drive(1, 32'h123452B7, 0, 1, 0, 0);
    drive(1, 32'h12345297, 32'h100, 1, 0, 0);
    drive(1, 32'h00000000, 0, 1, 0, 0);
    drive(1, 32'h01080833, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    drive(1, 32'h002081B3, 0, 1, 0, 0);
    repeat (3) drive(1, 32'h402081B3, 0, 0, 0, 0);
    drive(1, 32'h402081B3, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    drive(1, 32'h002081B3, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 32'h402081B3, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0);

    repeat (500)
      drive($urandom_range(0, 3) != 0, gen(), $urandom,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, 1);

    repeat (3) drive(0, 0, 0, 1, 0, 0);
    chk("queue_empty", 32'(q.size()), 0);
    mon_en = 1'b0;

    drive(1, 32'h002081B3, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(out_valid), 1);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_sel", 32'(alu_sel), 0);
    chk("midrst_a", alu_a, 0);
    chk("midrst_b", alu_b, 0);
    chk("midrst_rd", 32'(rd_addr), 0);
    chk("midrst_we", 32'(rd_we), 0);
    chk("midrst_ill", 32'(ill), 0);
    @(negedge clk);
    rstn     = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
